// File: rtl/kan_fixed_pkg.sv
// Shared fixed-point helpers and state encoding for the KAN tile accumulator codebase.
// Saturation works on a wide signed container so any lane width up to 63 bits fits.
package kan_fixed_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } kan_acc_state_e;

  localparam int unsigned SAT_CALC_W = 64;

  function automatic logic signed [SAT_CALC_W-1:0] sat_signed(
    input logic signed [SAT_CALC_W-1:0] value,
    input int unsigned                  width
  );
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    logic signed [SAT_CALC_W-1:0] res;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // A zero tile count still means one beat per group; oversize requests clamp.
  function automatic int unsigned clamp_tiles(
    input int unsigned cfg,
    input int unsigned max_tiles
  );
    int unsigned res;
    if (cfg == 0) begin
      res = 1;
    end else if (cfg > max_tiles) begin
      res = max_tiles;
    end else begin
      res = cfg;
    end
    return res;
  endfunction

endpackage

// File: rtl/kan_tile_accumulator_if.sv
// Stream bundle for the tile accumulator: partial-sum input stream and result output stream.
// The slave modport is the accumulator's view; master is the surrounding fabric.
interface kan_tile_accumulator_if #(
  parameter int CHANNELS       = 1,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int ID_WIDTH       = 8,
  parameter int DEST_WIDTH     = 8
);

  logic [CHANNELS*DATA_WIDTH_IN-1:0]  s_axis_psum_tdata;
  logic [CHANNELS-1:0]                s_axis_psum_tvalid;
  logic [CHANNELS-1:0]                s_axis_psum_tready;
  logic [CHANNELS-1:0]                s_axis_psum_tlast;

  logic [CHANNELS*DATA_WIDTH_OUT-1:0] m_axis_rslt_tdata;
  logic                               m_axis_rslt_tvalid;
  logic                               m_axis_rslt_tready;
  logic                               m_axis_rslt_tlast;
  logic [ID_WIDTH-1:0]                m_axis_rslt_tid;
  logic [DEST_WIDTH-1:0]              m_axis_rslt_tdest;

  modport slave (
    input  s_axis_psum_tdata,
    input  s_axis_psum_tvalid,
    input  s_axis_psum_tlast,
    output s_axis_psum_tready,
    output m_axis_rslt_tdata,
    output m_axis_rslt_tvalid,
    output m_axis_rslt_tlast,
    output m_axis_rslt_tid,
    output m_axis_rslt_tdest,
    input  m_axis_rslt_tready
  );

  modport master (
    output s_axis_psum_tdata,
    output s_axis_psum_tvalid,
    output s_axis_psum_tlast,
    input  s_axis_psum_tready,
    input  m_axis_rslt_tdata,
    input  m_axis_rslt_tvalid,
    input  m_axis_rslt_tlast,
    input  m_axis_rslt_tid,
    input  m_axis_rslt_tdest,
    output m_axis_rslt_tready
  );

endinterface

// File: rtl/kan_align_sat.sv
// Aligns one accumulated lane to the output fixed-point format and saturates it.
// Purely combinational; the arithmetic shift floors toward minus infinity.
module kan_align_sat
  import kan_fixed_pkg::*;
#(
  parameter int ACC_WIDTH      = 19,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int SHIFT          = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic [DATA_WIDTH_OUT-1:0]   data_o
);

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = acc_i >>> SHIFT;
  assign data_o  = DATA_WIDTH_OUT'(sat_signed(SAT_CALC_W'(shifted), DATA_WIDTH_OUT));

endmodule

// File: rtl/kan_tile_accumulator.sv
// Sums signed partial-sum lanes over a run-time number of tiles and emits one saturated
// result beat per group; a group always ends on its tile count, tlast is only checked.
module kan_tile_accumulator
  import kan_fixed_pkg::*;
#(
  parameter int CHANNELS       = 1,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int FRAC_BITS_IN   = 12,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int FRAC_BITS_OUT  = 12,
  parameter int MAX_TILES      = 8,
  parameter int TILE_CNT_W     = $clog2(MAX_TILES + 1),
  parameter int ACC_WIDTH      = DATA_WIDTH_IN + $clog2(MAX_TILES),
  parameter int ID_WIDTH       = 8,
  parameter int DEST_WIDTH     = 8,
  parameter int OUTPUT_ID      = 1,
  parameter int OUTPUT_DEST    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TILE_CNT_W-1:0] cfg_tiles,
  kan_tile_accumulator_if.slave axis,
  output logic                  err_unalligned_data,
  output logic                  err_tile_mismatch
);

  localparam int ALIGN_SHIFT = FRAC_BITS_IN - FRAC_BITS_OUT;

  kan_acc_state_e state_q, state_d;

  logic [TILE_CNT_W-1:0]              tile_cnt_q, tile_cnt_d;
  logic [TILE_CNT_W-1:0]              tiles_q, tiles_d;
  logic signed [ACC_WIDTH-1:0]        acc_q [CHANNELS];
  logic signed [ACC_WIDTH-1:0]        acc_d [CHANNELS];
  logic signed [ACC_WIDTH-1:0]        sum   [CHANNELS];
  logic [CHANNELS*DATA_WIDTH_OUT-1:0] tdata_q, tdata_d;
  logic [CHANNELS*DATA_WIDTH_OUT-1:0] aligned;
  logic                               tlast_q, tlast_d;
  logic                               err_unal_q, err_unal_d;
  logic                               err_tile_q, err_tile_d;

  logic                  s_ready;
  logic                  accept;
  logic                  first_beat;
  logic                  final_beat;
  logic                  m_handshake;
  logic                  all_last;
  logic                  any_last;
  logic [TILE_CNT_W-1:0] cfg_clamped;
  logic [TILE_CNT_W-1:0] group_tiles;

  assign cfg_clamped = TILE_CNT_W'(clamp_tiles(32'(cfg_tiles), MAX_TILES));

  // Ready is a function of state and downstream ready only, never of tvalid.
  assign s_ready     = !rst && ((state_q == ACCUM) || axis.m_axis_rslt_tready);
  assign accept      = s_ready && (&axis.s_axis_psum_tvalid);
  assign first_beat  = (tile_cnt_q == '0);
  assign group_tiles = first_beat ? cfg_clamped : tiles_q;
  assign final_beat  = accept && (tile_cnt_q == group_tiles - TILE_CNT_W'(1));
  assign m_handshake = (state_q == OUTPUT) && axis.m_axis_rslt_tready;
  assign all_last    = &axis.s_axis_psum_tlast;
  assign any_last    = |axis.s_axis_psum_tlast;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic signed [DATA_WIDTH_IN-1:0] lane;

    assign lane   = axis.s_axis_psum_tdata[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];
    // The first beat of a group loads rather than adds, so no stale sum leaks in.
    assign sum[i] = first_beat ? ACC_WIDTH'(lane) : acc_q[i] + ACC_WIDTH'(lane);

    kan_align_sat #(
      .ACC_WIDTH     (ACC_WIDTH),
      .DATA_WIDTH_OUT(DATA_WIDTH_OUT),
      .SHIFT         (ALIGN_SHIFT)
    ) u_align_sat (
      .acc_i (sum[i]),
      .data_o(aligned[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT])
    );
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    tiles_d    = tiles_q;
    acc_d      = acc_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    err_unal_d = accept && any_last && !all_last;
    err_tile_d = accept && (final_beat ? !all_last : any_last);

    if (accept) begin
      acc_d      = sum;
      tile_cnt_d = final_beat ? '0 : tile_cnt_q + TILE_CNT_W'(1);
      if (first_beat) begin
        tiles_d = cfg_clamped;
      end
    end

    if (final_beat) begin
      tdata_d = aligned;
      tlast_d = all_last;
    end

    unique case (state_q)
      ACCUM: begin
        if (final_beat) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        // A same-cycle final beat can only arrive alongside the handshake.
        if (m_handshake && !final_beat) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      tile_cnt_q <= '0;
      tiles_q    <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      err_unal_q <= 1'b0;
      err_tile_q <= 1'b0;
      // NOTE: the accumulator array is small (one word per lane), so it is reset like any register.
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      tiles_q    <= tiles_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      err_unal_q <= err_unal_d;
      err_tile_q <= err_tile_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign axis.s_axis_psum_tready = {CHANNELS{s_ready}};
  assign axis.m_axis_rslt_tvalid = (state_q == OUTPUT);
  assign axis.m_axis_rslt_tdata  = tdata_q;
  assign axis.m_axis_rslt_tlast  = tlast_q;
  assign axis.m_axis_rslt_tid    = ID_WIDTH'(OUTPUT_ID);
  assign axis.m_axis_rslt_tdest  = DEST_WIDTH'(OUTPUT_DEST);
  assign err_unalligned_data     = err_unal_q;
  assign err_tile_mismatch       = err_tile_q;

endmodule

// File: tb/tb_kan_tile_accumulator.sv
// Self-checking bench for kan_tile_accumulator: table vectors, directed corner sequences,
// and randomized groups checked against an integer-arithmetic reference model.
module tb_kan_tile_accumulator;

  localparam int CH   = 2;
  localparam int DWI  = 16;
  localparam int FIN  = 12;
  localparam int DWO  = 16;
  localparam int FOUT = 12;
  localparam int MAXT = 8;
  localparam int TCW  = $clog2(MAXT + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [TCW-1:0] cfg_tiles;
  logic           err_unal;
  logic           err_tile;

  always #5 clk = ~clk;

  kan_tile_accumulator_if #(
    .CHANNELS(CH), .DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .ID_WIDTH(8), .DEST_WIDTH(8)
  ) bus ();

  kan_tile_accumulator #(
    .CHANNELS(CH), .DATA_WIDTH_IN(DWI), .FRAC_BITS_IN(FIN),
    .DATA_WIDTH_OUT(DWO), .FRAC_BITS_OUT(FOUT), .MAX_TILES(MAXT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_tiles          (cfg_tiles),
    .axis               (bus),
    .err_unalligned_data(err_unal),
    .err_tile_mismatch  (err_tile)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CH*DWO-1:0] data;
    logic              last;
  } exp_t;

  exp_t   exp_q[$];
  int     m_cnt = 0;
  int     m_tiles = 1;
  longint m_sum[CH];
  int     exp_tile_err = 0;
  int     exp_unal_err = 0;

  function automatic int ref_tiles(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > MAXT) return MAXT;
    return cfg;
  endfunction

  // Floor division by 2^(FIN-FOUT), then clamp to the signed output range.
  function automatic logic [DWO-1:0] ref_lane(input longint total);
    longint d, q, hi, lo;
    d  = longint'(1) << (FIN - FOUT);
    q  = total / d;
    if ((total % d) != 0 && total < 0) q = q - 1;
    hi = (longint'(1) << (DWO - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[DWO-1:0];
  endfunction

  task automatic model_beat(input logic [CH*DWI-1:0] data, input logic [CH-1:0] last);
    bit   fin;
    exp_t e;
    if (m_cnt == 0) begin
      m_tiles = ref_tiles(int'(cfg_tiles));
      for (int i = 0; i < CH; i++) m_sum[i] = 0;
    end
    for (int i = 0; i < CH; i++) m_sum[i] += longint'($signed(data[i*DWI +: DWI]));
    m_cnt++;
    fin = (m_cnt == m_tiles);
    if (last != '0 && last != '1) exp_unal_err++;
    if (fin ? (last != '1) : (last != '0)) exp_tile_err++;
    if (fin) begin
      for (int i = 0; i < CH; i++) e.data[i*DWO +: DWO] = ref_lane(m_sum[i]);
      e.last = &last;
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // ---------------- output monitor ----------------
  int              hs_count = 0;
  int              obs_tile = 0;
  int              obs_unal = 0;
  logic [CH*DWO-1:0] last_out = '0;
  logic            last_out_last = 1'b0;
  exp_t            mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (err_tile) obs_tile++;
      if (err_unal) obs_unal++;
      if (bus.m_axis_rslt_tvalid && bus.m_axis_rslt_tready) begin
        hs_count++;
        last_out      = bus.m_axis_rslt_tdata;
        last_out_last = bus.m_axis_rslt_tlast;
        check("out_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("rslt_tdata", bus.m_axis_rslt_tdata, mon_e.data);
          check("rslt_tlast", bus.m_axis_rslt_tlast, mon_e.last);
          check("rslt_tid", bus.m_axis_rslt_tid, 1);
          check("rslt_tdest", bus.m_axis_rslt_tdest, 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.m_axis_rslt_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [CH*DWI-1:0] data, input logic [CH-1:0] last, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    bus.s_axis_psum_tdata  = data;
    bus.s_axis_psum_tlast  = last;
    bus.s_axis_psum_tvalid = '1;
    while (!done) begin
      @(negedge clk);
      if (&bus.s_axis_psum_tready) begin
        done = 1;
        model_beat(data, last);
      end else begin
        waits++;
      end
      tick();
      if (!done && waits > 200) begin
        check("accept_timeout", waits, 0);
        done = 1;
      end
    end
    bus.s_axis_psum_tvalid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [DWI-1:0] pick_lane();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [TCW-1:0]        tiles;
    logic [3:0][DWI-1:0]   l0;
    logic [3:0][DWI-1:0]   l1;
    logic [DWO-1:0]        e0;
    logic [DWO-1:0]        e1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    automatic int w = 0;
    automatic int stalls = 0;
    automatic int h0 = 0;
    automatic int t0 = 0;
    automatic int u0 = 0;
    automatic logic [CH*DWI-1:0] d = '0;
    automatic logic [CH-1:0] lst = '0;
    automatic int n = 0;
    automatic int rc = 0;

    vecs[0] = {4'd3, {16'h0000, 16'h0400, 16'h0800, 16'h1000},
                     {16'h0000, 16'h0010, 16'hFF00, 16'h0100}, 16'h1C00, 16'h0010};
    vecs[1] = {4'd4, {16'h7000, 16'h7000, 16'h7000, 16'h7000},
                     {16'h9000, 16'h9000, 16'h9000, 16'h9000}, 16'h7FFF, 16'h8000};
    vecs[2] = {4'd2, {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF},
                     {16'h0000, 16'h0000, 16'h8000, 16'h8000}, 16'h7FFF, 16'h8000};
    vecs[3] = {4'd4, {16'hFFFF, 16'h0001, 16'hC000, 16'h4000},
                     {16'h2000, 16'h2000, 16'h2000, 16'h2000}, 16'h0000, 16'h7FFF};

    rst = 1'b1;
    cfg_tiles = 3;
    bus.s_axis_psum_tdata  = '0;
    bus.s_axis_psum_tvalid = '0;
    bus.s_axis_psum_tlast  = '0;
    bus.m_axis_rslt_tready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_s_tready", bus.s_axis_psum_tready, 0);
    check("rst_m_tvalid", bus.m_axis_rslt_tvalid, 0);
    check("rst_m_tdata", bus.m_axis_rslt_tdata, 0);
    check("rst_m_tlast", bus.m_axis_rslt_tlast, 0);
    check("rst_err_tile", err_tile, 0);
    check("rst_err_unal", err_unal, 0);
    rst = 1'b0;
    #1;
    check("idle_s_tready", bus.s_axis_psum_tready, 2'b11);

    // Table-driven groups (accumulation and saturation)
    for (int v = 0; v < 4; v++) begin
      cfg_tiles = vecs[v].tiles;
      for (int b = 0; b < int'(vecs[v].tiles); b++) begin
        lst = (b == int'(vecs[v].tiles) - 1) ? 2'b11 : 2'b00;
        send_beat({vecs[v].l1[b], vecs[v].l0[b]}, lst, w);
      end
      drain();
      check("tbl_lane0", last_out[DWO-1:0], vecs[v].e0);
      check("tbl_lane1", last_out[2*DWO-1:DWO], vecs[v].e1);
      check("tbl_tlast", last_out_last, 1);
    end

    // One tile per group, back-to-back with full throughput
    cfg_tiles = 1;
    h0 = hs_count;
    stalls = 0;
    for (int b = 0; b < 8; b++) begin
      send_beat({pick_lane(), pick_lane()}, 2'b11, w);
      stalls += w;
    end
    tick();
    check("b2b_outputs", hs_count - h0, 8);
    check("b2b_stalls", stalls, 0);
    drain();

    // Backpressure holds the result and blocks input
    bus.m_axis_rslt_tready = 1'b0;
    h0 = hs_count;
    send_beat({16'h0123, 16'h0456}, 2'b11, w);
    bus.s_axis_psum_tdata  = {16'h0777, 16'h0888};
    bus.s_axis_psum_tlast  = 2'b11;
    bus.s_axis_psum_tvalid = '1;
    for (int c = 0; c < 5; c++) begin
      check("bp_m_tvalid", bus.m_axis_rslt_tvalid, 1);
      check("bp_m_tdata", bus.m_axis_rslt_tdata, {16'h0123, 16'h0456});
      check("bp_s_tready", bus.s_axis_psum_tready, 0);
      tick();
    end
    bus.m_axis_rslt_tready = 1'b1;
    send_beat({16'h0777, 16'h0888}, 2'b11, w);
    check("bp_release_wait", w, 0);
    drain();
    check("bp_handshakes", hs_count - h0, 2);

    // Tile-count and lane-alignment errors
    cfg_tiles = 2;
    t0 = obs_tile;
    u0 = obs_unal;
    send_beat({16'h0100, 16'h0100}, 2'b11, w);
    send_beat({16'h0100, 16'h0100}, 2'b11, w);
    drain();
    check("early_tlast_err", obs_tile - t0, 1);
    check("early_tlast_data", last_out, {16'h0200, 16'h0200});
    send_beat({16'h0010, 16'h0010}, 2'b00, w);
    send_beat({16'h0010, 16'h0010}, 2'b01, w);
    drain();
    tick();
    check("unal_err", obs_unal - u0, 1);
    check("missing_tlast_err", obs_tile - t0, 2);
    check("unal_tlast_out", last_out_last, 0);

    // Reset mid-group discards partial sums
    cfg_tiles = 3;
    send_beat({16'h5000, 16'h5000}, 2'b00, w);
    send_beat({16'h5000, 16'h5000}, 2'b00, w);
    h0 = hs_count;
    rst = 1'b1;
    repeat (2) tick();
    check("midrst_s_tready", bus.s_axis_psum_tready, 0);
    check("midrst_m_tvalid", bus.m_axis_rslt_tvalid, 0);
    rst = 1'b0;
    m_cnt = 0;
    tick();
    check("midrst_no_out", hs_count - h0, 0);
    for (int b = 0; b < 3; b++) send_beat({16'h1000, 16'h1000}, (b == 2) ? 2'b11 : 2'b00, w);
    drain();
    check("post_rst_sum0", last_out[DWO-1:0], 16'h3000);
    check("post_rst_sum1", last_out[2*DWO-1:DWO], 16'h3000);

    // Zero tile count behaves as one
    cfg_tiles = 0;
    h0 = hs_count;
    send_beat({16'hF800, 16'h0800}, 2'b11, w);
    drain();
    check("cfg0_outputs", hs_count - h0, 1);
    check("cfg0_lane0", last_out[DWO-1:0], 16'h0800);
    check("cfg0_lane1", last_out[2*DWO-1:DWO], 16'hF800);

    // Randomized groups with random downstream backpressure
    rand_ready = 1;
    for (int g = 0; g < 40; g++) begin
      rc = $urandom_range(0, 15);
      cfg_tiles = TCW'(rc);
      n = ref_tiles(rc);
      for (int b = 0; b < n; b++) begin
        d = {pick_lane(), pick_lane()};
        lst = (b == n - 1) ? 2'b11 : 2'b00;
        if ($urandom_range(0, 7) == 0) lst = 2'($urandom);
        send_beat(d, lst, w);
      end
    end
    rand_ready = 0;
    bus.m_axis_rslt_tready = 1'b1;
    drain();
    repeat (2) tick();
    check("total_tile_err", obs_tile, exp_tile_err);
    check("total_unal_err", obs_unal, exp_unal_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
